// File: rtl/vpu_resp_model.sv
// vpu_resp_model
//   Stand-in for the vector unit when the CPU runs without the real VPU.
//   Commands from the CPU are queued in a small FIFO. Each command is held
//   for LAT busy cycles and is then written back over the VPU_rdy /
//   VPU_data_we handshake that the CPU already uses.
//
// Parameters
//   DATA_W  lane and RO width
//   NUM_V   number of vector lanes
//   LAT     busy cycles per command (1..255)
//   QDEPTH  command FIFO depth (power of two, >= 2)
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   start_VPU         command strobe (accepted when VPU_rdy is high)
//   op_VPU, code_VPU  operation select, shift amount
//   obj_num_VPU       tag, returned unchanged on obj_num_out
//   V_in, RO_in       vector lanes (lane i at [i*DATA_W +: DATA_W]), scalar
//   VPU_rdy           FIFO has room (0 while rst is high)
//   VPU_data_we       one-cycle result-valid pulse
//   V_out, RO_out     registered results, held until the next write-back
//   obj_num_out       tag of the last write-back
//   pending           queued commands plus the one in flight
//   err               sticky error flag
//
// Build option
//   VPU_MODEL_CHECK_EN  when defined, err latches on a start while not
//                       ready and on execution of an illegal op. When
//                       undefined, err is tied to 0.

module vpu_resp_model #(
  parameter int DATA_W = 16,
  parameter int NUM_V  = 8,
  parameter int LAT    = 4,
  parameter int QDEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_VPU,
  input  logic [3:0]                  op_VPU,
  input  logic [3:0]                  code_VPU,
  input  logic [4:0]                  obj_num_VPU,
  input  logic [NUM_V*DATA_W-1:0]     V_in,
  input  logic [DATA_W-1:0]           RO_in,
  output logic                        VPU_rdy,
  output logic                        VPU_data_we,
  output logic [NUM_V*DATA_W-1:0]     V_out,
  output logic [DATA_W-1:0]           RO_out,
  output logic [4:0]                  obj_num_out,
  output logic [$clog2(QDEPTH+1):0]   pending,
  output logic                        err
);

  localparam int VW = NUM_V * DATA_W;
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = CW + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_WB} state_t;

  // Per-lane operation. The result is taken modulo 2^DATA_W. The shift
  // right is arithmetic because the lane operand is signed.
  function automatic logic [DATA_W-1:0] lane_op(
    input logic [3:0]               op,
    input logic [3:0]               sh,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] ro
  );
    logic [DATA_W-1:0] r;
    r = '0;
    case (op)
      4'd1:    r = a;
      4'd2:    r = a + ro;
      4'd3:    r = a - ro;
      4'd4:    r = a << sh;
      4'd5:    r = a >>> sh;
      default: r = '0;
    endcase
    return r;
  endfunction

  // ---- stage p0: command FIFO ----
  logic [3:0]        op_mem_p0   [QDEPTH];
  logic [3:0]        code_mem_p0 [QDEPTH];
  logic [4:0]        obj_mem_p0  [QDEPTH];
  logic [VW-1:0]     v_mem_p0    [QDEPTH];
  logic [DATA_W-1:0] ro_mem_p0   [QDEPTH];
  logic [AW-1:0]     wr_ptr_p0, rd_ptr_p0;
  logic [CW-1:0]     count_p0;
  logic              full_p0, push_p0, pop_p0;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;

  assign full_p0 = (count_p0 == CW'(QDEPTH));
  assign VPU_rdy = ~rst & ~full_p0;
  assign push_p0 = start_VPU & VPU_rdy;
  assign pop_p0  = (state_q == S_IDLE) && (count_p0 != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      count_p0  <= '0;
    end else begin
      if (push_p0) wr_ptr_p0 <= wr_ptr_p0 + AW'(1);
      if (pop_p0)  rd_ptr_p0 <= rd_ptr_p0 + AW'(1);
      case ({push_p0, pop_p0})
        2'b10:   count_p0 <= count_p0 + CW'(1);
        2'b01:   count_p0 <= count_p0 - CW'(1);
        default: count_p0 <= count_p0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_p0) begin
      op_mem_p0[wr_ptr_p0]   <= op_VPU;
      code_mem_p0[wr_ptr_p0] <= code_VPU;
      obj_mem_p0[wr_ptr_p0]  <= obj_num_VPU;
      v_mem_p0[wr_ptr_p0]    <= V_in;
      ro_mem_p0[wr_ptr_p0]   <= RO_in;
    end
  end

  // ---- stage p1: working registers and latency engine ----
  logic [3:0]        op_p1, code_p1;
  logic [4:0]        obj_p1;
  logic [VW-1:0]     v_p1;
  logic [DATA_W-1:0] ro_p1;
  logic [VW-1:0]     res_v_p1;
  logic [DATA_W-1:0] res_ro_p1;
  logic              nop_p1, wb_p1;

  always_ff @(posedge clk) begin
    if (pop_p0) begin
      op_p1   <= op_mem_p0[rd_ptr_p0];
      code_p1 <= code_mem_p0[rd_ptr_p0];
      obj_p1  <= obj_mem_p0[rd_ptr_p0];
      v_p1    <= v_mem_p0[rd_ptr_p0];
      ro_p1   <= ro_mem_p0[rd_ptr_p0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pop_p0) begin
          state_d = S_BUSY;
          cnt_d   = 8'(LAT - 1);
        end
      end
      S_BUSY: begin
        if (cnt_q == 8'd0) state_d = S_WB;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    res_v_p1 = '0;
    for (int i = 0; i < NUM_V; i++) begin
      res_v_p1[i*DATA_W +: DATA_W] = lane_op(op_p1, code_p1, v_p1[i*DATA_W +: DATA_W], ro_p1);
    end
  end

  // Legal ops pass RO through; illegal ops zero it.
  assign res_ro_p1 = (op_p1 >= 4'd1 && op_p1 <= 4'd5) ? ro_p1 : '0;
  assign nop_p1    = (op_p1 == 4'd0);
  assign wb_p1     = (state_q == S_WB) && !nop_p1;

  // ---- stage p2: registered write-back ----
  logic vld_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2      <= 1'b0;
      V_out       <= '0;
      RO_out      <= '0;
      obj_num_out <= '0;
    end else begin
      vld_p2 <= wb_p1;
      if (wb_p1) begin
        V_out       <= res_v_p1;
        RO_out      <= res_ro_p1;
        obj_num_out <= obj_p1;
      end
    end
  end

  assign VPU_data_we = vld_p2;
  assign pending     = PW'(count_p0) + PW'(state_q != S_IDLE);

`ifdef VPU_MODEL_CHECK_EN
  logic err_q;
  logic illegal_p1;

  assign illegal_p1 = (op_p1 > 4'd5);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((start_VPU && !VPU_rdy) || ((state_q == S_WB) && illegal_p1)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
